// File: rtl/dca_matrix_row_loader.sv
// Packs a valid/ready scalar stream into matrix rows for the DCA matrix register's
// row-move port; zero rows are appended so every load writes exactly N rows.
module dca_matrix_row_loader #(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR,
    parameter int BW_DIM           = $clog2(MATRIX_SIZE_PARA + 1)
) (
    input  logic                        clk,
    input  logic                        rstnn,
    input  logic                        start,
    input  logic [BW_DIM-1:0]           num_row,
    input  logic [BW_DIM-1:0]           num_col,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [BW_TENSOR_SCALAR-1:0] s_data,
    output logic                        init,
    output logic                        move_wenable,
    output logic [BW_TENSOR_ROW-1:0]    move_wdata_list,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {IDLE, INIT, FILL, PAD, DONE} state_t;

    localparam logic [BW_DIM-1:0] N_DIM  = BW_DIM'(MATRIX_SIZE_PARA);
    localparam logic [BW_DIM-1:0] N_LAST = BW_DIM'(MATRIX_SIZE_PARA - 1);

    state_t                      state;
    state_t                      state_next;
    logic [BW_DIM-1:0]           row_cnt;
    logic [BW_DIM-1:0]           col_cnt;
    logic [BW_DIM-1:0]           rows;
    logic [BW_DIM-1:0]           cols;
    logic [BW_TENSOR_SCALAR-1:0] buffer [MATRIX_SIZE_PARA];
    logic [BW_TENSOR_ROW-1:0]    row_word;
    logic                        row_wen;
    logic [BW_TENSOR_ROW-1:0]    row_data;
    logic                        fire;
    logic                        row_end;

    function automatic logic [BW_DIM-1:0] clamp_dim(input logic [BW_DIM-1:0] v);
        return (v > N_DIM) ? N_DIM : v;
    endfunction

    assign fire    = s_valid && s_ready;
    assign row_end = fire && (col_cnt == cols - BW_DIM'(1));

    always_ff @(posedge clk) begin
        if (!rstnn) state <= IDLE;
        else        state <= state_next;
    end

    // FILL lingers one cycle after the last data row so that row's strobe is not
    // overlapped by done; PAD then follows without a gap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = INIT;
            INIT: state_next = (rows == '0 || cols == '0) ? PAD : FILL;
            FILL: if (row_cnt == rows) state_next = (row_cnt == N_DIM) ? DONE : PAD;
            PAD:  if (row_cnt == N_LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready         = (state == FILL) && (row_cnt != rows);
        init            = (state == INIT);
        busy            = (state != IDLE);
        done            = (state == DONE);
        move_wenable    = row_wen || (state == PAD);
        move_wdata_list = row_data;
    end

    // Completed row: buffered columns plus the scalar arriving this cycle.
    always_comb begin
        row_word = '0;
        for (int c = 0; c < MATRIX_SIZE_PARA; c++) begin
            row_word[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] =
                (col_cnt == BW_DIM'(c)) ? s_data : buffer[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            row_cnt  <= '0;
            col_cnt  <= '0;
            rows     <= '0;
            cols     <= '0;
            row_wen  <= 1'b0;
            row_data <= '0;
            for (int c = 0; c < MATRIX_SIZE_PARA; c++) buffer[c] <= '0;
        end else begin
            row_wen  <= 1'b0;
            row_data <= '0;
            for (int c = 0; c < MATRIX_SIZE_PARA; c++) begin
                if (row_end)
                    buffer[c] <= '0;
                else if (fire && col_cnt == BW_DIM'(c))
                    buffer[c] <= s_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        rows    <= clamp_dim(num_row);
                        cols    <= clamp_dim(num_col);
                        row_cnt <= '0;
                        col_cnt <= '0;
                    end
                end
                FILL: begin
                    if (row_end) begin
                        row_wen  <= 1'b1;
                        row_data <= row_word;
                        col_cnt  <= '0;
                        row_cnt  <= row_cnt + BW_DIM'(1);
                    end else if (fire) begin
                        col_cnt  <= col_cnt + BW_DIM'(1);
                    end
                end
                PAD:     row_cnt <= row_cnt + BW_DIM'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dca_matrix_row_loader.sv
// Directed bench for dca_matrix_row_loader with N=4 and 8-bit scalars.
module tb_dca_matrix_row_loader;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int RW = N * SW;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rstnn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] num_row = '0;
    logic [DW-1:0] num_col = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_data = '0;
    logic          init;
    logic          move_wenable;
    logic [RW-1:0] move_wdata_list;
    logic          busy;
    logic          done;

    int tests_run = 0;
    int tests_failed = 0;

    int init_cnt, init_first, wen_cnt, done_cnt, done_cyc, busy_fall;
    int hs_cnt, ready_cnt, bad_overlap, bad_wdata;
    int wen_cyc [16];
    logic [RW-1:0] wen_dat [16];
    int hs_cyc [64];

    dca_matrix_row_loader #(
        .MATRIX_SIZE_PARA(N),
        .BW_TENSOR_SCALAR(SW)
    ) dut (
        .clk(clk),
        .rstnn(rstnn),
        .start(start),
        .num_row(num_row),
        .num_col(num_col),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .init(init),
        .move_wenable(move_wenable),
        .move_wdata_list(move_wdata_list),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a load at cycle 0 and record every observable event until busy falls.
    task automatic run_load(input logic [DW-1:0] nr, input logic [DW-1:0] nc,
                            input int vperiod, input int mid_start);
        int sidx;
        start = 1'b1; num_row = nr; num_col = nc; s_valid = 1'b0;
        tick();
        start = 1'b0;
        init_cnt = 0; init_first = -1; wen_cnt = 0; done_cnt = 0; done_cyc = -1;
        busy_fall = -1; hs_cnt = 0; ready_cnt = 0; bad_overlap = 0; bad_wdata = 0;
        sidx = 0;
        for (int k = 1; k < 300; k++) begin
            if (k == mid_start) begin
                start = 1'b1; num_row = 3'd1; num_col = 3'd1;
            end else begin
                start = 1'b0;
            end
            s_valid = ((k % vperiod) == 0);
            s_data  = SW'(sidx + 1);
            if (init) begin
                init_cnt++;
                if (init_first < 0) init_first = k;
            end
            if (move_wenable) begin
                if (wen_cnt < 16) begin
                    wen_cyc[wen_cnt] = k;
                    wen_dat[wen_cnt] = move_wdata_list;
                end
                wen_cnt++;
            end else if (move_wdata_list != '0) begin
                bad_wdata++;
            end
            if (init && move_wenable) bad_overlap++;
            if (done) begin done_cnt++; done_cyc = k; end
            if (s_ready) ready_cnt++;
            if (s_valid && s_ready) begin
                if (hs_cnt < 64) hs_cyc[hs_cnt] = k;
                hs_cnt++;
                sidx++;
            end
            if (!busy) begin busy_fall = k; break; end
            tick();
        end
        s_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        tick();
        tick();
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        tests_run++; if (init !== 1'b0) begin tests_failed++; $display("FAIL reset_init got %b want 0", init); end
        tests_run++; if (move_wenable !== 1'b0) begin tests_failed++; $display("FAIL reset_wen got %b want 0", move_wenable); end
        tests_run++; if (move_wdata_list !== '0) begin tests_failed++; $display("FAIL reset_wdata got %h want 0", move_wdata_list); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        rstnn = 1'b1;
        tick();
    endtask

    // Full 4x4 load; first_wen/spacing give the hand-computed strobe timing.
    task automatic test_full_load(input string name, input logic [DW-1:0] nr,
                                  input int vperiod, input int mid_start,
                                  input int first_wen, input int spacing);
        logic [RW-1:0] exp_dat [4];
        int last_wen;
        exp_dat[0] = 32'h04030201; exp_dat[1] = 32'h08070605;
        exp_dat[2] = 32'h0C0B0A09; exp_dat[3] = 32'h100F0E0D;
        last_wen = first_wen + 3 * spacing;
        run_load(nr, 3'd4, vperiod, mid_start);
        tests_run++; if (init_cnt !== 1 || init_first !== 1) begin tests_failed++; $display("FAIL %s init count %0d at %0d want 1 at 1", name, init_cnt, init_first); end
        tests_run++; if (hs_cnt !== 16) begin tests_failed++; $display("FAIL %s handshakes got %0d want 16", name, hs_cnt); end
        tests_run++; if (hs_cyc[0] !== ((vperiod == 1) ? 2 : 3)) begin tests_failed++; $display("FAIL %s first handshake cycle %0d", name, hs_cyc[0]); end
        tests_run++; if (wen_cnt !== 4) begin tests_failed++; $display("FAIL %s wen count got %0d want 4", name, wen_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (wen_dat[i] !== exp_dat[i]) begin tests_failed++; $display("FAIL %s row%0d data got %h want %h", name, i, wen_dat[i], exp_dat[i]); end
            tests_run++; if (wen_cyc[i] !== first_wen + i * spacing) begin tests_failed++; $display("FAIL %s row%0d cycle got %0d want %0d", name, i, wen_cyc[i], first_wen + i * spacing); end
            tests_run++; if (wen_cyc[i] !== hs_cyc[4*i+3] + 1) begin tests_failed++; $display("FAIL %s row%0d strobe got %0d want last handshake+1 = %0d", name, i, wen_cyc[i], hs_cyc[4*i+3] + 1); end
        end
        tests_run++; if (done_cnt !== 1 || done_cyc !== last_wen + 1) begin tests_failed++; $display("FAIL %s done count %0d at %0d want 1 at %0d", name, done_cnt, done_cyc, last_wen + 1); end
        tests_run++; if (busy_fall !== last_wen + 2) begin tests_failed++; $display("FAIL %s busy fall got %0d want %0d", name, busy_fall, last_wen + 2); end
        tests_run++; if (bad_overlap !== 0 || bad_wdata !== 0) begin tests_failed++; $display("FAIL %s overlap %0d stray wdata %0d want 0 0", name, bad_overlap, bad_wdata); end
    endtask

    task automatic test_partial();
        int            exp_cyc [4];
        logic [RW-1:0] exp_dat [4];
        exp_cyc[0] = 5; exp_cyc[1] = 8; exp_cyc[2] = 9; exp_cyc[3] = 10;
        exp_dat[0] = 32'h00030201; exp_dat[1] = 32'h00060504; exp_dat[2] = '0; exp_dat[3] = '0;
        run_load(3'd2, 3'd3, 1, -1);
        tests_run++; if (hs_cnt !== 6) begin tests_failed++; $display("FAIL partial handshakes got %0d want 6", hs_cnt); end
        tests_run++; if (wen_cnt !== 4) begin tests_failed++; $display("FAIL partial wen count got %0d want 4", wen_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (wen_dat[i] !== exp_dat[i] || wen_cyc[i] !== exp_cyc[i]) begin tests_failed++; $display("FAIL partial row%0d got %h at %0d want %h at %0d", i, wen_dat[i], wen_cyc[i], exp_dat[i], exp_cyc[i]); end
        end
        tests_run++; if (done_cyc !== 11 || done_cnt !== 1) begin tests_failed++; $display("FAIL partial done count %0d at %0d want 1 at 11", done_cnt, done_cyc); end
        tests_run++; if (busy_fall !== 12) begin tests_failed++; $display("FAIL partial busy fall got %0d want 12", busy_fall); end
    endtask

    task automatic test_zero_size();
        run_load(3'd0, 3'd4, 1, -1);
        tests_run++; if (init_first !== 1 || init_cnt !== 1) begin tests_failed++; $display("FAIL zero init count %0d at %0d want 1 at 1", init_cnt, init_first); end
        tests_run++; if (ready_cnt !== 0 || hs_cnt !== 0) begin tests_failed++; $display("FAIL zero s_ready cycles %0d handshakes %0d want 0 0", ready_cnt, hs_cnt); end
        tests_run++; if (wen_cnt !== 4) begin tests_failed++; $display("FAIL zero wen count got %0d want 4", wen_cnt); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (wen_dat[i] !== '0 || wen_cyc[i] !== 2 + i) begin tests_failed++; $display("FAIL zero row%0d got %h at %0d want 0 at %0d", i, wen_dat[i], wen_cyc[i], 2 + i); end
        end
        tests_run++; if (done_cyc !== 6) begin tests_failed++; $display("FAIL zero done cycle got %0d want 6", done_cyc); end
        tests_run++; if (busy_fall !== 7) begin tests_failed++; $display("FAIL zero busy fall got %0d want 7", busy_fall); end
    endtask

    task automatic test_mid_reset();
        int hs;
        int k;
        bit seen;
        hs = 0;
        k = 1;
        start = 1'b1; num_row = 3'd4; num_col = 3'd4;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        while (hs < 6 && k < 50) begin
            s_data = SW'(hs + 1);
            if (s_valid && s_ready) hs++;
            tick();
            k++;
        end
        tests_run++; if (hs !== 6) begin tests_failed++; $display("FAIL midreset handshakes got %0d want 6", hs); end
        s_valid = 1'b0;
        rstnn = 1'b0;
        tick();
        tests_run++; if (s_ready !== 1'b0 || init !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL midreset control ready=%b init=%b busy=%b done=%b want 0", s_ready, init, busy, done); end
        tests_run++; if (move_wenable !== 1'b0 || move_wdata_list !== '0) begin tests_failed++; $display("FAIL midreset write wen=%b data=%h want 0 0", move_wenable, move_wdata_list); end
        rstnn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (move_wenable || busy) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL midreset activity after reset got %b want 0", seen); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_load("full", 3'd4, 1, -1, 6, 4);
        test_partial();
        test_full_load("bubbles", 3'd4, 3, -1, 13, 12);
        test_zero_size();
        test_full_load("clamp", 3'd7, 1, -1, 6, 4);
        test_full_load("ignored_start", 3'd4, 1, 6, 6, 4);
        test_mid_reset();
        test_full_load("after_reset", 3'd4, 1, -1, 6, 4);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
